uart_block_packer: RTL and testbench

//  Upstream stage of the AES encryption datapath. Packs UART RX byte ticks into 128-bit blocks.

---
 rtl/uart_block_packer.sv | 157 +++++++++++++++
 tb/tb_uart_block_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_packer.sv
// uart_block_packer: packs UART RX byte ticks into 128-bit blocks for the AES
// encryption datapath. Completed blocks go through a small first-word-fall-through
// block FIFO and are presented on a valid/ready port.
// Partial blocks are padded with PAD_BYTE and pushed on flush_i or after
// TIMEOUT_CYCLES idle cycles (0 disables the timeout).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   rx_data_i, rx_valid_i    received byte and its 1-cycle valid tick
//   flush_i                  pad and push the current partial block
//   blk_data_o, blk_valid_o  FIFO head block (byte k at [8k+7:8k]) and non-empty flag
//   blk_ready_i              consumer pops the head on valid & ready
//   byte_cnt_o               bytes held in the partial block
//   fill_o                   completed blocks stored
//   overflow_o               sticky: a completed block was dropped
module uart_block_packer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  input  logic                          flush_i,
  output logic [127:0]                  blk_data_o,
  output logic                          blk_valid_o,
  input  logic                          blk_ready_i,
  output logic [3:0]                    byte_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          overflow_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = PW + 1;

  typedef enum logic {
    ASM_IDLE,
    ASM_FILL
  } asm_state_t;

  asm_state_t     asm_state;
  logic [3:0]     byte_cnt;
  logic [127:0]   partial;
  logic [31:0]    tcnt;

  logic [127:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [FW-1:0]  fill;
  logic [127:0]   head_q;
  logic           valid_q;
  logic           overflow_q;

  logic [127:0]   asm_blk;
  logic [127:0]   push_data;
  logic [4:0]     held_after;
  logic           complete;
  logic           timeout_hit;
  logic           flush_req;
  logic           push;
  logic           pop;
  logic           full;
  logic           push_ok;
  logic           drop;
  logic [FW-1:0]  fill_next;
  logic [PW-1:0]  rd_next;

  // Assembler: the incoming byte is merged first, then flush/timeout padding
  // applies to whatever lanes remain unused.
  always_comb begin
    asm_blk = partial;
    if (rx_valid_i)
      asm_blk[{byte_cnt, 3'b000} +: 8] = rx_data_i;
    held_after  = rx_valid_i ? ({1'b0, byte_cnt} + 5'd1) : {1'b0, byte_cnt};
    complete    = rx_valid_i && (byte_cnt == 4'd15);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (asm_state == ASM_FILL) && !rx_valid_i &&
                  (tcnt == 32'(TIMEOUT_CYCLES - 1));
    flush_req   = (flush_i || timeout_hit) && !complete &&
                  ((asm_state == ASM_FILL) || rx_valid_i);
    push        = complete || flush_req;
    push_data   = asm_blk;
    for (int unsigned i = 0; i < 16; i++) begin
      if (5'(i) >= held_after)
        push_data[i*8 +: 8] = PAD_BYTE;
    end
  end

  // FIFO control
  always_comb begin
    pop       = valid_q && blk_ready_i;
    full      = (fill == FW'(FIFO_DEPTH));
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    fill_next = fill + FW'(push_ok) - FW'(pop);
    rd_next   = rd_ptr + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_state <= ASM_IDLE;
      byte_cnt  <= '0;
      partial   <= '0;
      tcnt      <= '0;
    end else begin
      if (push) begin
        asm_state <= ASM_IDLE;
        byte_cnt  <= '0;
      end else if (rx_valid_i) begin
        asm_state <= ASM_FILL;
        byte_cnt  <= byte_cnt + 4'd1;
        partial   <= asm_blk;
      end
      if (rx_valid_i || push || (asm_state == ASM_IDLE))
        tcnt <= '0;
      else
        tcnt <= tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (drop)
        overflow_q <= 1'b1;
      rd_ptr  <= rd_next;
      fill    <= fill_next;
      valid_q <= (fill_next != '0);
      // Head register: take the block being pushed when nothing else remains
      // queued, otherwise the stored entry at the next read pointer.
      if (fill_next != '0) begin
        if (fill == FW'(pop))
          head_q <= push_data;
        else
          head_q <= mem[rd_next];
      end
    end
  end

  assign blk_data_o  = head_q;
  assign blk_valid_o = valid_q;
  assign byte_cnt_o  = byte_cnt;
  assign fill_o      = fill;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_block_packer.sv
module tb_uart_block_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data_i;
  logic         rx_valid_i;
  logic         flush_i;
  logic [127:0] blk_data_o;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [3:0]   byte_cnt_o;
  logic [2:0]   fill_o;
  logic         overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_block_packer #(
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(100),
    .PAD_BYTE(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .flush_i(flush_i),
    .blk_data_o(blk_data_o),
    .blk_valid_o(blk_valid_o),
    .blk_ready_i(blk_ready_i),
    .byte_cnt_o(byte_cnt_o),
    .fill_o(fill_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Block b carries byte {b[3:0], k[3:0]} in lane k.
  function automatic logic [127:0] mk_blk(input int b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[k*8 +: 8] = {4'(b), 4'(k)};
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_block(input int b);
    logic [127:0] d;
    d = mk_blk(b);
    for (int k = 0; k < 16; k++)
      send_byte(d[k*8 +: 8]);
  endtask

  task automatic pop_check(input logic [127:0] exp, input string name);
    n_checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== exp) begin
      n_fail++;
      $display("FAIL %s: valid=%b data=%h, expected valid=1 data=%h", name, blk_valid_o, blk_data_o, exp);
    end
    blk_ready_i = 1'b1;
    @(negedge clk);
    blk_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({blk_valid_o, blk_data_o, byte_cnt_o, fill_o, overflow_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h cnt=%0d fill=%0d ovf=%b, expected all 0",
               blk_valid_o, blk_data_o, byte_cnt_o, fill_o, overflow_o);
    end
  endtask

  task automatic test_single_block();
    blk_ready_i = 1'b1;
    for (int k = 0; k < 16; k++)
      send_byte(8'(k));
    n_checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== 128'h0F0E0D0C0B0A09080706050403020100 || fill_o !== 3'd1) begin
      n_fail++;
      $display("FAIL single_block: valid=%b data=%h fill=%0d, expected valid=1 data=0f0e..0100 fill=1",
               blk_valid_o, blk_data_o, fill_o);
    end
    @(negedge clk);
    n_checks++;
    if (blk_valid_o !== 1'b0 || fill_o !== 3'd0 || byte_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL single_block_drained: valid=%b fill=%0d cnt=%0d, expected 0 0 0",
               blk_valid_o, fill_o, byte_cnt_o);
    end
    blk_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    for (int b = 1; b <= 5; b++)
      send_block(b);
    n_checks++;
    if (fill_o !== 3'd4 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: fill=%0d ovf=%b, expected fill=4 ovf=1", fill_o, overflow_o);
    end
    blk_ready_i = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      n_checks++;
      if (blk_valid_o !== 1'b1 || blk_data_o !== mk_blk(b)) begin
        n_fail++;
        $display("FAIL overflow_order_%0d: valid=%b data=%h, expected valid=1 data=%h",
                 b, blk_valid_o, blk_data_o, mk_blk(b));
      end
      @(negedge clk);
    end
    blk_ready_i = 1'b0;
    n_checks++;
    if (blk_valid_o !== 1'b0 || fill_o !== 3'd0 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drained: valid=%b fill=%0d ovf=%b, expected 0 0 1",
               blk_valid_o, fill_o, overflow_o);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++)
      send_byte(8'hAA);
    n_checks++;
    if (byte_cnt_o !== 4'd5 || blk_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_partial: cnt=%0d valid=%b, expected cnt=5 valid=0", byte_cnt_o, blk_valid_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== 128'h0000000000000000000000AAAAAAAAAA ||
        byte_cnt_o !== 4'd0 || fill_o !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_pad: valid=%b data=%h cnt=%0d fill=%0d, expected 1 ..aaaaaaaaaa 0 1",
               blk_valid_o, blk_data_o, byte_cnt_o, fill_o);
    end
    // byte and flush together in idle: one-byte padded block
    flush_i = 1'b1;
    send_byte(8'h55);
    flush_i = 1'b0;
    // 16th byte with flush: one full block, no extra empty block
    for (int k = 0; k < 15; k++)
      send_byte({4'h3, 4'(k)});
    flush_i = 1'b1;
    send_byte(8'h3F);
    flush_i = 1'b0;
    n_checks++;
    if (fill_o !== 3'd3 || byte_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_with_byte: fill=%0d cnt=%0d, expected fill=3 cnt=0", fill_o, byte_cnt_o);
    end
    pop_check(128'h0000000000000000000000AAAAAAAAAA, "flush_head0");
    pop_check(128'h00000000000000000000000000000055, "flush_head1");
    pop_check(mk_blk(3), "flush_head2");
  endtask

  task automatic test_timeout();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (99) @(negedge clk);
    n_checks++;
    if (blk_valid_o !== 1'b0 || byte_cnt_o !== 4'd3) begin
      n_fail++;
      $display("FAIL timeout_early: valid=%b cnt=%0d, expected valid=0 cnt=3", blk_valid_o, byte_cnt_o);
    end
    @(negedge clk);
    n_checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== 128'h00000000000000000000000000030201 || byte_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_push: valid=%b data=%h cnt=%0d, expected 1 ..030201 0",
               blk_valid_o, blk_data_o, byte_cnt_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (110) @(negedge clk);
    n_checks++;
    if (fill_o !== 3'd1) begin
      n_fail++;
      $display("FAIL idle_flush_ignored: fill=%0d, expected 1", fill_o);
    end
    pop_check(128'h00000000000000000000000000030201, "timeout_head");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int b = 0; b < 4; b++)
      send_block(b);
    for (int k = 0; k < 15; k++)
      send_byte({4'h4, 4'(k)});
    blk_ready_i = 1'b1;
    send_byte(8'h4F);
    blk_ready_i = 1'b0;
    n_checks++;
    if (fill_o !== 3'd4 || overflow_o !== 1'b0 || blk_data_o !== mk_blk(1)) begin
      n_fail++;
      $display("FAIL full_push_pop: fill=%0d ovf=%b head=%h, expected fill=4 ovf=0 head=%h",
               fill_o, overflow_o, blk_data_o, mk_blk(1));
    end
    pop_check(mk_blk(1), "b2b_head1");
    pop_check(mk_blk(2), "b2b_head2");
    pop_check(mk_blk(3), "b2b_head3");
    pop_check(mk_blk(4), "b2b_head4");
  endtask

  task automatic test_mid_reset();
    send_block(6);
    send_block(7);
    for (int k = 0; k < 7; k++)
      send_byte(8'hC0);
    do_reset();
    n_checks++;
    if ({blk_valid_o, blk_data_o, byte_cnt_o, fill_o, overflow_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h cnt=%0d fill=%0d ovf=%b, expected all 0",
               blk_valid_o, blk_data_o, byte_cnt_o, fill_o, overflow_o);
    end
    send_block(9);
    n_checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== mk_blk(9) || fill_o !== 3'd1 || byte_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_block: valid=%b data=%h fill=%0d cnt=%0d, expected 1 %h 1 0",
               blk_valid_o, blk_data_o, fill_o, byte_cnt_o, mk_blk(9));
    end
  endtask

  initial begin
    reset       = 1'b1;
    rx_data_i   = '0;
    rx_valid_i  = 1'b0;
    flush_i     = 1'b0;
    blk_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_block();
    test_overflow();
    do_reset();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
